// File: rtl/memory_responder.sv
// Byte-addressable big-endian memory answering the MFA/MOC handshake after a fixed wait.
// Optional macro RESP_ALIGN_CHK_EN adds the ALIGN_ERR output and rejects misaligned accesses.
module memory_responder #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              MFA,
  input  logic              RW,
  input  logic [1:0]        DT,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [31:0]       DATA_IN,
  output logic [31:0]       DATA_OUT,
  output logic              MOC
`ifdef RESP_ALIGN_CHK_EN
  ,
  output logic              ALIGN_ERR
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

`ifdef RESP_ALIGN_CHK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  state_t            state;
  logic [3:0]        cnt;
  logic              rw_q;
  logic [1:0]        dt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;

  logic [7:0]        mem [2**ADDR_W];

  logic [ADDR_W-1:0] base, a1, a2, a3;
  logic              misaligned;
  logic              commit;
  logic              wr_en;
  logic [31:0]       rd_data;

  // NOTE: every signal written here gets a default first, so no path leaves a latch.
  always_comb begin
    base       = addr_q;
    misaligned = 1'b0;
    case (dt_q)
      2'b00: ;
      2'b01: begin
        misaligned = addr_q[0];
        base[0]    = 1'b0;
      end
      default: begin
        misaligned = |addr_q[1:0];
        base[1:0]  = 2'b00;
      end
    endcase
    a1 = base + ADDR_W'(1);
    a2 = base + ADDR_W'(2);
    a3 = base + ADDR_W'(3);
  end

  always_comb begin
    commit = (state == BUSY) && MFA && (cnt == 4'd0);
    wr_en  = commit && !RESET && !rw_q && !(ALIGN_CHK && misaligned);
    case (dt_q)
      2'b00:   rd_data = {24'h0, mem[base]};
      2'b01:   rd_data = {16'h0, mem[base], mem[a1]};
      default: rd_data = {mem[base], mem[a1], mem[a2], mem[a3]};
    endcase
  end

  // NOTE: the storage array is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      case (dt_q)
        2'b00: mem[base] <= data_q[7:0];
        2'b01: begin
          mem[base] <= data_q[15:8];
          mem[a1]   <= data_q[7:0];
        end
        default: begin
          mem[base] <= data_q[31:24];
          mem[a1]   <= data_q[23:16];
          mem[a2]   <= data_q[15:8];
          mem[a3]   <= data_q[7:0];
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      MOC      <= 1'b0;
      DATA_OUT <= 32'h0;
      rw_q     <= 1'b0;
      dt_q     <= 2'b00;
      addr_q   <= '0;
      data_q   <= 32'h0;
`ifdef RESP_ALIGN_CHK_EN
      ALIGN_ERR <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          MOC <= 1'b0;
          if (MFA) begin
            rw_q   <= RW;
            dt_q   <= DT;
            addr_q <= ADDR;
            data_q <= DATA_IN;
            cnt    <= 4'(WAIT_CYCLES);
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (!MFA) begin
            state <= IDLE;
          end else if (cnt == 4'd0) begin
            MOC   <= 1'b1;
            state <= DONE;
            if (ALIGN_CHK && misaligned) begin
`ifdef RESP_ALIGN_CHK_EN
              ALIGN_ERR <= 1'b1;
`endif
            end else if (rw_q) begin
              DATA_OUT <= rd_data;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (!MFA) begin
            MOC   <= 1'b0;
            state <= IDLE;
`ifdef RESP_ALIGN_CHK_EN
            ALIGN_ERR <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: two instances (WAIT_CYCLES 2 and 0) checked against a byte-array model.
// Honours RESP_ALIGN_CHK_EN when the design is built with it.
module tb_memory_responder;

`ifdef RESP_ALIGN_CHK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset [2];
  logic        mfa   [2];
  logic        rw    [2];
  logic [1:0]  dt    [2];
  logic [7:0]  addr  [2];
  logic [31:0] din   [2];
  logic [31:0] dout  [2];
  logic        moc   [2];
`ifdef RESP_ALIGN_CHK_EN
  logic        aerr  [2];
`endif

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  ref_mem  [2][256];
  logic [31:0] exp_dout [2];
  logic [31:0] got;

  always #5 clk = ~clk;

  memory_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut (
    .CLK(clk), .RESET(reset[0]), .MFA(mfa[0]), .RW(rw[0]), .DT(dt[0]),
    .ADDR(addr[0]), .DATA_IN(din[0]), .DATA_OUT(dout[0]), .MOC(moc[0])
`ifdef RESP_ALIGN_CHK_EN
    , .ALIGN_ERR(aerr[0])
`endif
  );

  memory_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .CLK(clk), .RESET(reset[1]), .MFA(mfa[1]), .RW(rw[1]), .DT(dt[1]),
    .ADDR(addr[1]), .DATA_IN(din[1]), .DATA_OUT(dout[1]), .MOC(moc[1])
`ifdef RESP_ALIGN_CHK_EN
    , .ALIGN_ERR(aerr[1])
`endif
  );

  function automatic int wait_of(int u);
    return (u == 0) ? 2 : 0;
  endfunction

  function automatic int size_of(logic [1:0] d);
    return (d == 2'b00) ? 1 : (d == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_read(int u, int base, int n);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[u][(base + i) % 256]);
    return v;
  endfunction

  task automatic model_write(int u, int base, int n, logic [31:0] d);
    for (int i = 0; i < n; i++) ref_mem[u][(base + i) % 256] = 8'(d >> (8 * (n - 1 - i)));
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full handshake; inputs are scrambled after the accept edge, which the responder must ignore.
  task automatic op(int u, bit r, logic [1:0] d, logic [7:0] a, logic [31:0] data,
                    int hold, bit rst_overlap, output logic [31:0] result);
    int n, base, cycles;
    bit ae;
    n    = size_of(d);
    base = int'(a) - (int'(a) % n);
    ae   = ALIGN_CHK && ((int'(a) % n) != 0);
    rw[u] = r; dt[u] = d; addr[u] = a; din[u] = data; mfa[u] = 1'b1;
    if (rst_overlap) begin
      reset[u] = 1'b1;
      step;
      reset[u] = 1'b0;
      exp_dout[u] = 32'h0;
      check("rst_mfa_moc", 32'(moc[u]), 32'd0);
      check("rst_mfa_dout", dout[u], 32'h0);
    end
    if (r && !ae) exp_dout[u] = model_read(u, base, n);
    cycles = 0;
    while (moc[u] !== 1'b1 && cycles <= 40) begin
      step;
      cycles++;
      if (cycles == 1) begin
        rw[u] = ~r; dt[u] = ~d; addr[u] = ~a; din[u] = ~data;
      end
    end
    if (moc[u] !== 1'b1) begin
      checks++;
      errors++;
      $error("FAIL moc_timeout observed=%b expected=1", moc[u]);
    end else begin
      check("latency", 32'(cycles), 32'(wait_of(u) + 2));
    end
    check("data_out", dout[u], exp_dout[u]);
`ifdef RESP_ALIGN_CHK_EN
    check("align_err", 32'(aerr[u]), 32'(ae));
`endif
    result = dout[u];
    if (!r && !ae) model_write(u, base, n, data);
    for (int i = 0; i < hold; i++) begin
      step;
      check("moc_hold", 32'(moc[u]), 32'd1);
      check("dout_hold", dout[u], exp_dout[u]);
    end
    mfa[u] = 1'b0;
    step;
    check("moc_fall", 32'(moc[u]), 32'd0);
`ifdef RESP_ALIGN_CHK_EN
    check("align_err_fall", 32'(aerr[u]), 32'd0);
`endif
  endtask

  // Accepts a request, then kills it in BUSY either by dropping MFA or by RESET.
  task automatic abort_req(int u, bit r, logic [1:0] d, logic [7:0] a, logic [31:0] data,
                           int busy, bit use_rst);
    rw[u] = r; dt[u] = d; addr[u] = a; din[u] = data; mfa[u] = 1'b1;
    step;
    for (int i = 0; i < busy; i++) step;
    if (use_rst) reset[u] = 1'b1;
    else         mfa[u]   = 1'b0;
    step;
    if (use_rst) exp_dout[u] = 32'h0;
    check("abort_moc", 32'(moc[u]), 32'd0);
    check("abort_dout", dout[u], exp_dout[u]);
    reset[u] = 1'b0;
    mfa[u]   = 1'b0;
    step;
    check("abort_idle_moc", 32'(moc[u]), 32'd0);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      reset[u] = 1'b1; mfa[u] = 1'b0; rw[u] = 1'b0; dt[u] = 2'b00;
      addr[u] = 8'h0; din[u] = 32'h0; exp_dout[u] = 32'h0;
    end
    repeat (3) step;
    for (int u = 0; u < 2; u++) begin
      check("reset_moc", 32'(moc[u]), 32'd0);
      check("reset_dout", dout[u], 32'h0);
`ifdef RESP_ALIGN_CHK_EN
      check("reset_align_err", 32'(aerr[u]), 32'd0);
`endif
      reset[u] = 1'b0;
    end
    step;

    // Word write/read and big-endian byte lanes
    op(0, 1'b0, 2'b10, 8'h10, 32'h11223344, 0, 1'b0, got);
    op(0, 1'b1, 2'b10, 8'h10, 32'h0, 0, 1'b0, got);
    check("rd_word_10", got, 32'h11223344);
    op(0, 1'b1, 2'b00, 8'h10, 32'h0, 0, 1'b0, got);
    check("rd_byte_10", got, 32'h00000011);
    op(0, 1'b1, 2'b00, 8'h13, 32'h0, 0, 1'b0, got);
    check("rd_byte_13", got, 32'h00000044);

    // Halfword and byte merge, read back while MFA stays high four cycles past MOC
    op(0, 1'b0, 2'b01, 8'h12, 32'h0000AABB, 0, 1'b0, got);
    op(0, 1'b0, 2'b00, 8'h10, 32'h000000CC, 0, 1'b0, got);
    op(0, 1'b1, 2'b10, 8'h10, 32'h0, 4, 1'b0, got);
    check("rd_merge", got, 32'hCC22AABB);

    // Abort by MFA drop, then by RESET on what would be the commit edge
    op(0, 1'b0, 2'b10, 8'h20, 32'h55667788, 0, 1'b0, got);
    abort_req(0, 1'b0, 2'b10, 8'h20, 32'hDEADBEEF, 1, 1'b0);
    abort_req(0, 1'b0, 2'b10, 8'h20, 32'h0BADF00D, 2, 1'b1);
    op(0, 1'b1, 2'b10, 8'h20, 32'h0, 0, 1'b1, got);
    check("rd_after_abort", got, 32'h55667788);

    // Misaligned word read
    op(0, 1'b1, 2'b10, 8'h11, 32'h0, 0, 1'b0, got);
`ifdef RESP_ALIGN_CHK_EN
    check("misaligned_rd", got, 32'h55667788);
`else
    check("misaligned_rd", got, 32'hCC22AABB);
`endif

    // Zero-wait instance, top-of-array word
    op(1, 1'b0, 2'b10, 8'hFC, 32'hA1B2C3D4, 0, 1'b0, got);
    op(1, 1'b1, 2'b00, 8'hFC, 32'h0, 0, 1'b0, got);
    check("rd_byte_fc", got, 32'h000000A1);
    op(1, 1'b1, 2'b00, 8'hFF, 32'h0, 0, 1'b0, got);
    check("rd_byte_ff", got, 32'h000000D4);
    op(1, 1'b1, 2'b01, 8'hFE, 32'h0, 1, 1'b0, got);
    op(1, 1'b1, 2'b10, 8'hFF, 32'h0, 0, 1'b0, got);

    // Randomized traffic in a preloaded window
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 16; i++)
        op(u, 1'b0, 2'b10, 8'(8'h40 + 4 * i), $urandom, 0, 1'b0, got);
      for (int i = 0; i < 30; i++)
        op(u, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           8'(8'h40 + $urandom_range(0, 63)), $urandom, $urandom_range(0, 2), 1'b0, got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
